decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised RV32I decode stage between fetch and register-file read.
//  Splits the instruction into opcode/funct3/funct7/rs1/rs2/rd fields, as the combinational field decoder does.
//  Adds: format classification, sign-extended immediate generation, illegal-opcode flagging, PC passthrough.
//  Adds a valid/ready handshake with an optional skid buffer, plus pipeline flush.
// PARAMETERS
//  XLEN   32  immediate output width (32 or 64); immediates are sign-extended to XLEN
//  PC_W   32  width of the program-counter sideband
//  SKID   1   1 = two-entry skid buffer (full throughput, registered in_ready); 0 = single register, in_ready = !out_valid | out_ready
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       discard all held instructions (branch redirect)
//  in_valid   in   1       fetch presents an instruction
//  in_ready   out  1       stage accepts an instruction this cycle
//  in_instr   in   32      raw instruction
//  in_pc      in   PC_W    PC of in_instr
//  out_valid  out  1       decoded bundle valid
//  out_ready  in   1       downstream accepts the bundle
//  out_pc     out  PC_W    PC of the decoded instruction
//  cmd_op     out  7       instr[6:0]
//  cmd_f3     out  3       instr[14:12]
//  cmd_f7     out  7       instr[31:25]
//  rs1/rs2/rd out  5 each  instr[19:15] / [24:20] / [11:7]
//  fmt        out  3       format: R=0, I=1, S=2, B=3, U=4, J=5
//  imm        out  XLEN    sign-extended immediate per fmt; 0 for R
//  illegal    out  1       opcode not in RV32I base set, or instr[1:0] != 2'b11
// BEHAVIOUR
//  - One clock, one synchronous active-high reset.
//  - Reset: out_valid=0, all data outputs 0, skid empty; in_ready=1 on the first cycle after reset deasserts.
//  - Accept when in_valid & in_ready; deliver when out_valid & out_ready. Latency: 1 cycle, accept -> out_valid.
//  - Decode is combinational on in_instr and registered into the output stage. All outputs are flop-driven.
//  - Opcode -> fmt:
//      0110011 -> R
//      0010011, 0000011, 1100111, 1110011, 0001111 -> I
//      0100011 -> S
//      1100011 -> B
//      0110111, 0010111 -> U
//      1101111 -> J
//      any other opcode -> illegal=1, fmt=I, imm=0
//  - Immediates; bit 31 is the sign, replicated up to XLEN:
//      I: instr[31:20]
//      S: {instr[31:25], instr[11:7]}
//      B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
//      U: {instr[31:12], 12'b0}
//      J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
//  - Output stage holds its bundle stable while out_valid & !out_ready.
//  - SKID=1:
//      Accept while the output is stalled -> the instruction goes to the skid register.
//      in_ready = !skid_full, registered.
//      When the output drains, skid contents move to the output next cycle.
//      Order is always preserved.
//  - SKID=0: in_ready = !out_valid | out_ready (combinational path).
//  - Simultaneous deliver + accept: output reloads with the new bundle; out_valid stays 1; no bubble.
//  - flush: next cycle out_valid=0, skid empty, in_ready=1.
//      flush overrides a same-cycle accept; that instruction is dropped.
//  - reset overrides flush and handshakes; reset mid-stall discards held instructions.
// STRUCTURE
//  - Shared package riscv_pkg:
//      opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE)
//      fmt_e enum
//      dec_bundle_t struct (pc, fields, fmt, imm, illegal)
//  - Sub-module imm_gen: combinational instr -> {fmt, imm, illegal}, reused by later compressed/64-bit decoders.
//  - Top level: imm_gen, output register, skid register, handshake control.
// TESTING
//  - addi x1,x0,5 (0x00500093): out_valid 1 cycle after accept; rd=1, rs1=0, cmd_f3=0, fmt=I, imm=5, illegal=0.
//  - sw x2,-4(x1) (0xFE20AE23) -> fmt=S, rs1=1, rs2=2, cmd_f3=2, imm=0xFFFFFFFC; with XLEN=64, imm=0xFFFF_FFFF_FFFF_FFFC.
//  - lui x5,0x12345 (0x123452B7) -> fmt=U, rd=5, imm=0x12345000.
//    jal x1,-8 (0xFF9FF0EF) -> fmt=J, rd=1, imm=0xFFFFFFF8.
//  - 0x00000000 and 0x0000007F -> illegal=1, fmt=I, imm=0; fields still reported.
//  - SKID=1, 3 back-to-back instrs (pc 0x0,0x4,0x8), out_ready=0 for 3 cycles:
//      in_ready drops after the second accept.
//      The third is held at input.
//      Delivery order after out_ready=1 is 0x0, 0x4, 0x8, with no drop and no duplicate.
//  - flush with skid full and a same-cycle in_valid -> next cycle out_valid=0, in_ready=1; none of the three ever delivered.
//    Reset asserted mid-stall gives the same result.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode values, instruction formats and
// the decoded-field bundle passed between decode and register-file read.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Widest sideband/immediate any decoder variant produces
  localparam int XLEN_MAX = 64;
  localparam int PC_W_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Fixed-width part of a decoded instruction
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    fmt_e       fmt;
    logic       illegal;
  } dec_fields_t;

  // Full bundle as seen by consumers sized for the widest configuration
  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    dec_fields_t         fields;
    logic [XLEN_MAX-1:0] imm;
  } dec_bundle_t;

  // Slice the fixed register/function fields out of a raw instruction
  function automatic dec_fields_t split_fields(input logic [31:0] instr,
                                               input fmt_e        fmt,
                                               input logic        illegal);
    dec_fields_t f;
    f.op      = instr[6:0];
    f.f3      = instr[14:12];
    f.f7      = instr[31:25];
    f.rs1     = instr[19:15];
    f.rs2     = instr[24:20];
    f.rd      = instr[11:7];
    f.fmt     = fmt;
    f.illegal = illegal;
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
// Unknown opcodes report illegal with format I and a zero immediate.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output fmt_e            fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [31:0] imm32_s;

  // Map the opcode onto its instruction format and flag anything outside RV32I
  always_comb begin
    fmt_o     = FMT_I;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OP_R:                                        fmt_o = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: fmt_o = FMT_I;
      OP_STORE:                                    fmt_o = FMT_S;
      OP_BRANCH:                                   fmt_o = FMT_B;
      OP_LUI, OP_AUIPC:                            fmt_o = FMT_U;
      OP_JAL:                                      fmt_o = FMT_J;
      default: begin
        fmt_o     = FMT_I;
        illegal_o = 1'b1;
      end
    endcase
  end

  // Assemble the 32-bit immediate for the classified format
  always_comb begin
    imm32_s = 32'h0000_0000;
    if (illegal_o) begin
      imm32_s = 32'h0000_0000;
    end else begin
      case (fmt_o)
        FMT_I:   imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
        FMT_S:   imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        FMT_B:   imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
        FMT_U:   imm32_s = {instr_i[31:12], 12'h000};
        FMT_J:   imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
        default: imm32_s = 32'h0000_0000;
      endcase
    end
  end

  // Bit 31 is always the sign, so widening is a plain signed extension
  assign imm_o = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, optional
// two-entry skid buffer and branch-redirect flush.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      cmd_op,
  output logic [2:0]      cmd_f3,
  output logic [6:0]      cmd_f7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  fmt_e            in_fmt_s;
  logic            in_illegal_s;
  logic [XLEN-1:0] in_imm_s;
  dec_fields_t     in_fields_s;
  logic            accept_s;
  logic            out_free_s;

  logic            out_valid_q, out_valid_d;
  dec_fields_t     out_f_q,     out_f_d;
  logic [PC_W-1:0] out_pc_q,    out_pc_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;

  logic            skid_valid_q, skid_valid_d;
  dec_fields_t     skid_f_q,     skid_f_d;
  logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;

  logic            in_ready_q, in_ready_d;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i   (in_instr),
    .fmt_o     (in_fmt_s),
    .imm_o     (in_imm_s),
    .illegal_o (in_illegal_s)
  );

  assign in_fields_s = split_fields(in_instr, in_fmt_s, in_illegal_s);

  // Without a skid slot the stage can only take a new instruction when the
  // output register is empty or being drained in the same cycle
  assign in_ready   = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready;
  assign out_free_s = !out_valid_q || out_ready;

  // Next-state for output and skid slots; the skid entry is always older
  // than anything arriving at the input, so it refills the output first
  always_comb begin
    out_valid_d  = out_valid_q;
    out_f_d      = out_f_q;
    out_pc_d     = out_pc_q;
    out_imm_d    = out_imm_q;
    skid_valid_d = skid_valid_q;
    skid_f_d     = skid_f_q;
    skid_pc_d    = skid_pc_q;
    skid_imm_d   = skid_imm_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_free_s) begin
        out_valid_d  = 1'b1;
        out_f_d      = skid_f_q;
        out_pc_d     = skid_pc_q;
        out_imm_d    = skid_imm_q;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (accept_s) begin
      if (out_free_s) begin
        out_valid_d = 1'b1;
        out_f_d     = in_fields_s;
        out_pc_d    = in_pc;
        out_imm_d   = in_imm_s;
      end else begin
        skid_valid_d = 1'b1;
        skid_f_d     = in_fields_s;
        skid_pc_d    = in_pc;
        skid_imm_d   = in_imm_s;
      end
    end else if (out_free_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    in_ready_d = !skid_valid_d;
  end

  // Pipeline registers; reset clears every held instruction and its data
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_f_q      <= '0;
      out_pc_q     <= '0;
      out_imm_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_f_q     <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_f_q      <= out_f_d;
      out_pc_q     <= out_pc_d;
      out_imm_q    <= out_imm_d;
      skid_valid_q <= skid_valid_d;
      skid_f_q     <= skid_f_d;
      skid_pc_q    <= skid_pc_d;
      skid_imm_q   <= skid_imm_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign cmd_op    = out_f_q.op;
  assign cmd_f3    = out_f_q.f3;
  assign cmd_f7    = out_f_q.f7;
  assign rs1       = out_f_q.rs1;
  assign rs2       = out_f_q.rs2;
  assign rd        = out_f_q.rd;
  assign fmt       = out_f_q.fmt;
  assign imm       = out_imm_q;
  assign illegal   = out_f_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, randomized scoreboard run and
// hand-written skid / flush / reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  // DUT A: XLEN=32, SKID=1
  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] out_pc_a, imm_a;
  logic [6:0]  op_a, f7_a;
  logic [2:0]  f3_a, fmt_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;

  // DUT B: XLEN=64, SKID=0
  logic        in_ready_b, out_valid_b, illegal_b;
  logic [31:0] out_pc_b;
  logic [63:0] imm_b;
  logic [6:0]  op_b, f7_b;
  logic [2:0]  f3_b, fmt_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;

  int n_vec = 0;
  int n_mis = 0;

  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .cmd_op(op_a), .cmd_f3(f3_a), .cmd_f7(f7_a), .rs1(rs1_a),
    .rs2(rs2_a), .rd(rd_a), .fmt(fmt_a), .imm(imm_a), .illegal(illegal_a)
  );

  decode_stage #(.XLEN(64), .PC_W(32), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .cmd_op(op_b), .cmd_f3(f3_b), .cmd_f7(f7_b), .rs1(rs1_b),
    .rs2(rs2_b), .rd(rd_b), .fmt(fmt_b), .imm(imm_b), .illegal(illegal_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          fmt;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

  // Reference decode straight from the format table and immediate layouts
  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] instr);
    exp_t       e;
    logic [6:0] op;
    op = instr[6:0];
    e.pc = pc;
    e.instr = instr;
    e.illegal = 1'b0;
    e.imm = 64'd0;
    e.fmt = 1;
    if (op == 7'h33) e.fmt = 0;
    else if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) e.fmt = 1;
    else if (op == 7'h23) e.fmt = 2;
    else if (op == 7'h63) e.fmt = 3;
    else if (op inside {7'h37, 7'h17}) e.fmt = 4;
    else if (op == 7'h6F) e.fmt = 5;
    else e.illegal = 1'b1;
    if (!e.illegal) begin
      case (e.fmt)
        1: e.imm = 64'($signed(instr[31:20]));
        2: e.imm = 64'($signed({instr[31:25], instr[11:7]}));
        3: e.imm = 64'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        4: e.imm = 64'($signed({instr[31:12], 12'h000}));
        5: e.imm = 64'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        default: e.imm = 64'd0;
      endcase
    end
    return e;
  endfunction

  task automatic chk_bundle(input string tag, input exp_t e);
    chk({tag, "_pc"},  out_pc_a, e.pc);
    chk({tag, "_op"},  op_a,  e.instr[6:0]);
    chk({tag, "_f3"},  f3_a,  e.instr[14:12]);
    chk({tag, "_f7"},  f7_a,  e.instr[31:25]);
    chk({tag, "_rs1"}, rs1_a, e.instr[19:15]);
    chk({tag, "_rs2"}, rs2_a, e.instr[24:20]);
    chk({tag, "_rd"},  rd_a,  e.instr[11:7]);
    chk({tag, "_fmt"}, fmt_a, 64'(e.fmt));
    chk({tag, "_imm"}, imm_a, {32'd0, e.imm[31:0]});
    chk({tag, "_ill"}, illegal_a, e.illegal);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h0F, 7'h7F};
    r = $urandom();
    if (r[3:0] == 4'hF) return r[10:4];
    return ops[$urandom_range(0, 11)];
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          fmt;
    logic [63:0] imm;
    logic        ill;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
  } vec_t;

  vec_t        vt[11];
  exp_t        q[$];
  exp_t        e;
  logic [31:0] got[$];
  logic [31:0] r;
  logic [31:0] pc_ctr;
  logic        acc;
  int          cnt;

  initial begin
    vt[0]  = '{32'h00500093, 1, 64'd5,                  1'b0, 5'd1,  5'd0,  5'd5,  3'd0};
    vt[1]  = '{32'hFE20AE23, 2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd28, 5'd1,  5'd2,  3'd2};
    vt[2]  = '{32'h123452B7, 4, 64'h0000_0000_1234_5000, 1'b0, 5'd5,  5'd8,  5'd3,  3'd5};
    vt[3]  = '{32'hFF9FF0EF, 5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 5'd1,  5'd31, 5'd25, 3'd7};
    vt[4]  = '{32'h00000000, 1, 64'd0,                  1'b1, 5'd0,  5'd0,  5'd0,  3'd0};
    vt[5]  = '{32'h0000007F, 1, 64'd0,                  1'b1, 5'd0,  5'd0,  5'd0,  3'd0};
    vt[6]  = '{32'h002081B3, 0, 64'd0,                  1'b0, 5'd3,  5'd1,  5'd2,  3'd0};
    vt[7]  = '{32'h00208463, 3, 64'd8,                  1'b0, 5'd8,  5'd1,  5'd2,  3'd0};
    vt[8]  = '{32'hFFFFF017, 4, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 5'd0,  5'd31, 5'd31, 3'd7};
    vt[9]  = '{32'hFFF12083, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1,  5'd2,  5'd31, 3'd2};
    vt[10] = '{32'h00500090, 1, 64'd0,                  1'b1, 5'd1,  5'd0,  5'd5,  3'd0};

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_in_ready",  in_ready_a,  1'b1);
    chk("rst_out_pc",    out_pc_a,    32'd0);
    chk("rst_imm",       imm_a,       32'd0);
    chk("rst_rd",        rd_a,        5'd0);
    chk("rst_b_valid",   out_valid_b, 1'b0);

    // Table-driven decode, one instruction per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'(i * 4);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), out_valid_a, 1'b1);
      chk($sformatf("vec%0d_pc", i),    out_pc_a,    32'(i * 4));
      chk($sformatf("vec%0d_fmt", i),   fmt_a,       64'(vt[i].fmt));
      chk($sformatf("vec%0d_imm", i),   imm_a,       {32'd0, vt[i].imm[31:0]});
      chk($sformatf("vec%0d_ill", i),   illegal_a,   vt[i].ill);
      chk($sformatf("vec%0d_rd", i),    rd_a,        vt[i].rd);
      chk($sformatf("vec%0d_rs1", i),   rs1_a,       vt[i].rs1);
      chk($sformatf("vec%0d_rs2", i),   rs2_a,       vt[i].rs2);
      chk($sformatf("vec%0d_f3", i),    f3_a,        vt[i].f3);
      chk($sformatf("vec%0d_op", i),    op_a,        vt[i].instr[6:0]);
      chk($sformatf("vec%0d_b_valid", i), out_valid_b, 1'b1);
      chk($sformatf("vec%0d_b_imm64", i), imm_b,     vt[i].imm);
    end
    in_valid = 1'b0;

    // Randomized traffic against the queue scoreboard
    do_reset();
    q.delete();
    pc_ctr = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      if (c >= 390) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      r = $urandom();
      in_instr = {r[31:7], pick_op()};
      in_pc = pc_ctr;
      @(negedge clk);
      chk("rnd_out_valid", out_valid_a, (q.size() != 0));
      chk("rnd_in_ready",  in_ready_a,  (q.size() < 2));
      if (out_valid_a && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk_bundle("rnd", e);
      end
      if (in_valid && in_ready_a) begin
        q.push_back(ref_dec(in_pc, in_instr));
        pc_ctr = pc_ctr + 32'd4;
      end
      @(posedge clk); #1;
    end
    chk("rnd_drained", q.size(), 0);

    // Skid: three back-to-back instructions under a 3-cycle stall
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    @(posedge clk); #1;
    chk("skid_rdy_after1", in_ready_a, 1'b1);
    chk("skid_valid1",     out_valid_a, 1'b1);
    chk("s0_rdy_stalled",  in_ready_b, 1'b0);
    in_instr = 32'h002081B3; in_pc = 32'h4;
    @(posedge clk); #1;
    chk("skid_rdy_after2", in_ready_a, 1'b0);
    chk("skid_pc_hold1",   out_pc_a, 32'h0);
    in_instr = 32'hFE20AE23; in_pc = 32'h8;
    @(posedge clk); #1;
    chk("skid_rdy_held",   in_ready_a, 1'b0);
    chk("skid_pc_hold2",   out_pc_a, 32'h0);
    chk("skid_imm_hold",   imm_a, 32'd5);
    out_ready = 1'b1; #1;
    chk("s0_rdy_comb",     in_ready_b, 1'b1);
    got.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid_a) got.push_back(out_pc_a);
      acc = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk("skid_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk($sformatf("skid_order%0d", i), got[i], 32'(i * 4));
    end

    // Flush with skid full and a same-cycle input
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h10;
    @(posedge clk); #1;
    in_pc = 32'h14;
    @(posedge clk); #1;
    in_pc = 32'h18; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid_a, 1'b0);
    chk("flush_in_ready",  in_ready_a,  1'b1);
    chk("flush_b_valid",   out_valid_b, 1'b0);
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid_a) cnt++;
      @(posedge clk); #1;
    end
    chk("flush_no_deliver", cnt, 0);

    // Flush overrides an accept that would otherwise succeed
    in_valid = 1'b1; in_pc = 32'h20; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_drop", out_valid_a, 1'b0);

    // Reset in the middle of a stall
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h30;
    @(posedge clk); #1;
    in_pc = 32'h34;
    @(posedge clk); #1;
    in_pc = 32'h38; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("rstmid_out_valid", out_valid_a, 1'b0);
    chk("rstmid_in_ready",  in_ready_a,  1'b1);
    chk("rstmid_out_pc",    out_pc_a,    32'h0);
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid_a) cnt++;
      @(posedge clk); #1;
    end
    chk("rstmid_no_deliver", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
